sort_sequencer: RTL and testbench
=================================

SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 SHALL have parameter W, default 32, meaning key width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, meaning keys per sorting-network chunk.
REQ-003 SHALL have parameter WAYS, default 8, meaning merge-tree input ways (power of 2, 2..16).
REQ-004 SHALL have parameter CPW, default 1, meaning chunks per way per run; TOTAL = WAYS*CPW*CHUNK keys.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, meaning a single-cycle request to begin a run.
REQ-008 SHALL have port din, input, CHUNK*W, meaning source chunk, key 0 in the MSBs.
REQ-009 SHALL have port din_valid, input, 1, meaning din holds a chunk.
REQ-010 SHALL have port din_ready, output, 1, meaning the chunk is accepted this cycle.
REQ-011 SHALL have port s_din, output, CHUNK*W, meaning registered chunk to the sorting network.
REQ-012 SHALL have port s_ena, output, 1, meaning sorting-network enable.
REQ-013 SHALL have port s_valid, input, 1, meaning sorting-network output valid.
REQ-014 SHALL have port im_ena, output, WAYS, meaning one-hot input-module enable.
REQ-015 SHALL have port im_req, input, WAYS, meaning input module has consumed its chunk and requests more.
REQ-016 SHALL have port t_deq, output, 1, meaning merge-tree dequeue.
REQ-017 SHALL have port t_empty, input, 1, meaning merge-tree root empty.
REQ-018 SHALL have port t_dout, input, W, meaning merge-tree output key.
REQ-019 SHALL have ports dout (output, W, registered output key), dout_valid (output, 1), dout_last (output, 1, marks key TOTAL-1).
REQ-020 SHALL have ports busy (output, 1, run in progress) and done (output, 1, run complete).

Function
REQ-021 SHALL implement states IDLE, LOAD, WAIT_NET, FEED, DRAIN, DONE.
REQ-022 IDLE: start=1 -> LOAD; chunk index c and word count n cleared to 0.
REQ-023 LOAD: din_ready = din_valid (combinational); on din_valid=1, s_din <= din, s_ena <= 1, -> WAIT_NET; s_ena stays 1 until DRAIN.
REQ-024 WAIT_NET: wait for s_valid=1, with no fixed latency, then -> FEED.
REQ-025 FEED: im_ena = one-hot bit (c mod WAYS) while s_valid=1; all zero otherwise.
REQ-026 FEED exit: when im_req[c mod WAYS]=1 sampled, im_ena <= 0 next cycle; if c = WAYS*CPW-1 -> DRAIN, else c <= c+1 and -> LOAD.
REQ-027 im_req bits of unselected ways SHALL be ignored.
REQ-028 At most one im_ena bit SHALL be high in any cycle.
REQ-029 DRAIN: t_deq=1, im_ena=0, s_ena=0; each cycle with t_empty=0, dout <= t_dout, dout_valid <= 1, n <= n+1; otherwise dout_valid <= 0 and dout holds.
REQ-030 DRAIN end: on the accepting cycle with n = TOTAL-1, dout_last <= 1 with that key, t_deq drops, -> DONE.
REQ-031 Word count n SHALL be clog2(TOTAL+1) bits and SHALL never exceed TOTAL.
REQ-032 DONE: done=1, outputs idle; start=1 -> LOAD with c and n cleared, done <= 0.
REQ-033 start SHALL be ignored in every state other than IDLE and DONE.
REQ-034 busy = 1 in LOAD, WAIT_NET, FEED and DRAIN.
REQ-035 din_ready SHALL be 0 outside LOAD; a chunk offered early SHALL wait without loss.

Reset
REQ-036 rst=1 forces IDLE asynchronously: s_din=0, s_ena=0, im_ena=0, t_deq=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0, c=0, n=0.
REQ-037 rst mid-run SHALL abort the run with no further din_ready, im_ena or t_deq pulses until a new start.

Verification
REQ-038 Default params, 8 chunks with din_valid always 1 and a network model with 12-cycle s_valid -> im_ena walks 0x01..0x80 in order; exactly 128 dout_valid pulses, nondecreasing; dout_last on the 128th; done=1.
REQ-039 din_valid withheld 20 cycles in LOAD -> din_ready=0 throughout, s_din unchanged, FSM stays in LOAD, then resumes.
REQ-040 t_empty toggled every other cycle in DRAIN -> dout_valid only on t_empty=0 cycles; total still 128; t_deq drops after the last key.
REQ-041 WAYS=4, CPW=2 -> im_ena sequence 1,2,4,8,1,2,4,8; TOTAL=128; dout_last at n=127.
REQ-042 rst pulsed during FEED of chunk 3 -> all outputs 0 immediately; start then restarts at chunk 0 with im_ena=0x01.
REQ-043 start during DRAIN -> ignored; start in DONE -> new run, done cleared the next cycle.

Source files
------------

// File: rtl/sort_sequencer_if.sv
// Handshake and data bundle between the sort sequencer and its sorting
// network, merge-tree input modules, merge-tree root and result sink.
interface sort_sequencer_if #(
    parameter int W     = 32,
    parameter int CHUNK = 16,
    parameter int WAYS  = 8
);
    logic                 start;
    logic [CHUNK*W-1:0]   din;
    logic                 din_valid;
    logic                 din_ready;
    logic [CHUNK*W-1:0]   s_din;
    logic                 s_ena;
    logic                 s_valid;
    logic [WAYS-1:0]      im_ena;
    logic [WAYS-1:0]      im_req;
    logic                 t_deq;
    logic                 t_empty;
    logic [W-1:0]         t_dout;
    logic [W-1:0]         dout;
    logic                 dout_valid;
    logic                 dout_last;
    logic                 busy;
    logic                 done;

    // Sequencer side.
    modport master (
        input  start, din, din_valid, s_valid, im_req, t_empty, t_dout,
        output din_ready, s_din, s_ena, im_ena, t_deq,
               dout, dout_valid, dout_last, busy, done
    );

    // Environment side (source, network, input modules, tree, sink).
    modport slave (
        output start, din, din_valid, s_valid, im_req, t_empty, t_dout,
        input  din_ready, s_din, s_ena, im_ena, t_deq,
               dout, dout_valid, dout_last, busy, done
    );
endinterface

// File: rtl/sort_sequencer.sv
// Sort sequencer: loads WAYS*CPW chunks one at a time through the sorting
// network, hands each sorted chunk to merge-tree input way (c mod WAYS),
// then drains TOTAL keys from the merge-tree root.
module sort_sequencer #(
    parameter int W     = 32,
    parameter int CHUNK = 16,
    parameter int WAYS  = 8,
    parameter int CPW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    sort_sequencer_if.master  bus
);
    localparam int NCHUNK = WAYS * CPW;
    localparam int TOTAL  = NCHUNK * CHUNK;
    localparam int NW     = $clog2(TOTAL + 1);
    localparam int CW     = $clog2(NCHUNK);
    localparam int SW     = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_NET, FEED, DRAIN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   c;
    logic [NW-1:0]   n;
    logic [SW-1:0]   way;
    logic [WAYS-1:0] way_oh;

    // WAYS is a power of two, so c mod WAYS is just the low bits of c.
    assign way    = c[SW-1:0];
    assign way_oh = WAYS'(1) << way;

    // Acceptance is combinational so an early-offered chunk simply waits.
    assign bus.din_ready = (state == LOAD) && bus.din_valid;

    // Run-control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            c              <= '0;
            n              <= '0;
            bus.s_din      <= '0;
            bus.s_ena      <= 1'b0;
            bus.im_ena     <= '0;
            bus.t_deq      <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_last  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.dout_valid <= 1'b0;
                    bus.dout_last  <= 1'b0;
                    if (bus.start) begin
                        state    <= LOAD;
                        c        <= '0;
                        n        <= '0;
                        bus.busy <= 1'b1;
                        bus.done <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.din_valid) begin
                        bus.s_din <= bus.din;
                        bus.s_ena <= 1'b1;
                        state     <= WAIT_NET;
                    end
                end
                WAIT_NET: begin
                    // Network latency is not fixed; its valid is the only cue.
                    if (bus.s_valid) begin
                        bus.im_ena <= way_oh;
                        state      <= FEED;
                    end
                end
                FEED: begin
                    // Only the selected way's request counts.
                    if (bus.im_req[way]) begin
                        bus.im_ena <= '0;
                        if (c == CW'(NCHUNK - 1)) begin
                            bus.t_deq <= 1'b1;
                            bus.s_ena <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            c     <= c + CW'(1);
                            state <= LOAD;
                        end
                    end else begin
                        bus.im_ena <= bus.s_valid ? way_oh : '0;
                    end
                end
                DRAIN: begin
                    if (!bus.t_empty) begin
                        bus.dout       <= bus.t_dout;
                        bus.dout_valid <= 1'b1;
                        n              <= n + NW'(1);
                        if (n == NW'(TOTAL - 1)) begin
                            bus.dout_last <= 1'b1;
                            bus.t_deq     <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= DONE;
                        end
                    end else begin
                        bus.dout_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: two instances (WAYS=8/CPW=1 and WAYS=4/CPW=2)
// driven in lockstep by a cycle-level environment (source, sorting network,
// input modules, merge tree). Expected values come from a sorted key queue
// and the one-hot way rule 1 << (chunk mod WAYS).
module tb_sort_sequencer;
    localparam int W = 32, CHUNK = 16, NCH = 8, TOTAL = 128;

    logic clk, rst;
    logic start, din_valid, s_valid, t_empty;
    logic [CHUNK*W-1:0] din;
    logic [W-1:0] t_dout;
    logic [7:0] req_a;
    logic [3:0] req_b;

    int n_chk = 0, n_fail = 0, cycles = 0;
    logic [CHUNK*W-1:0] chunks [NCH];
    logic [W-1:0] sorted [$];
    logic [CHUNK*W-1:0] exp_sdin;
    logic [W-1:0] exp_dout;

    sort_sequencer_if #(.W(W), .CHUNK(CHUNK), .WAYS(8)) ia ();
    sort_sequencer_if #(.W(W), .CHUNK(CHUNK), .WAYS(4)) ib ();

    assign ia.start = start;     assign ib.start = start;
    assign ia.din = din;         assign ib.din = din;
    assign ia.din_valid = din_valid; assign ib.din_valid = din_valid;
    assign ia.s_valid = s_valid; assign ib.s_valid = s_valid;
    assign ia.t_empty = t_empty; assign ib.t_empty = t_empty;
    assign ia.t_dout = t_dout;   assign ib.t_dout = t_dout;
    assign ia.im_req = req_a;    assign ib.im_req = req_b;

    sort_sequencer #(.W(W), .CHUNK(CHUNK), .WAYS(8), .CPW(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.master));
    sort_sequencer #(.W(W), .CHUNK(CHUNK), .WAYS(4), .CPW(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (outputs settled, inputs safe to change).
    task automatic tick();
        @(negedge clk);
        cycles++;
        if (cycles > 50000) begin
            $display("FAIL timeout: cycles %0d exceeds budget 50000", cycles);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // New key set; the merge tree is modelled as the fully sorted key list.
    task automatic gen_run();
        logic [W-1:0] key;
        sorted.delete();
        for (int k = 0; k < NCH; k++)
            for (int j = 0; j < CHUNK; j++) begin
                key = W'($urandom_range(0, 400));
                chunks[k][CHUNK*W-1-W*j -: W] = key;
                sorted.push_back(key);
            end
        sorted.sort();
    endtask

    task automatic run(input int hold_din, input bit toggle_empty, input int lat,
                       input int rst_chunk, input bit start_in_drain);
        int idx, cnt, f;
        bit acc, prev_acc;
        logic [7:0] oh_a;
        logic [3:0] oh_b;
        logic [W-1:0] prev_obs;
        gen_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_a", ia.busy, 1);
        chk("done_clr_a", ia.done, 0);
        chk("busy_start_b", ib.busy, 1);
        for (int k = 0; k < NCH; k++) begin
            if (hold_din > 0 && k == 2) begin
                din_valid = 1'b0;
                for (int h = 0; h < hold_din; h++) begin
                    #1;
                    chk("ready_hold", ia.din_ready, 0);
                    chk("sdin_hold", ia.s_din, exp_sdin);
                    chk("busy_hold", ia.busy, 1);
                    tick();
                end
            end
            din = chunks[k];
            din_valid = 1'b1;
            #1;
            chk("ready_load_a", ia.din_ready, 1);
            chk("ready_load_b", ib.din_ready, 1);
            tick();
            exp_sdin = chunks[k];
            chk("sdin_a", ia.s_din, exp_sdin);
            chk("sdin_b", ib.s_din, exp_sdin);
            chk("sena_a", ia.s_ena, 1);
            if (k < NCH - 1) din = chunks[k+1];
            for (int l = 0; l < lat; l++) begin
                #1;
                chk("ready_early", ia.din_ready, 0);
                chk("imena_wait_a", ia.im_ena, 0);
                start = (l == 1);
                tick();
            end
            start = 1'b0;
            s_valid = 1'b1;
            tick();
            oh_a = 8'(1 << (k % 8));
            oh_b = 4'(1 << (k % 4));
            f = $urandom_range(0, 3);
            for (int i = 0; i <= f; i++) begin
                chk("imena_feed_a", ia.im_ena, oh_a);
                chk("imena_feed_b", ib.im_ena, oh_b);
                chk("ready_feed", ia.din_ready, 0);
                if (k == rst_chunk) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_sdin", ia.s_din, 0);
                    chk("rst_sena", ia.s_ena, 0);
                    chk("rst_imena_a", ia.im_ena, 0);
                    chk("rst_imena_b", ib.im_ena, 0);
                    chk("rst_tdeq", ia.t_deq, 0);
                    chk("rst_dout", ia.dout, 0);
                    chk("rst_dvalid", ia.dout_valid, 0);
                    chk("rst_dlast", ia.dout_last, 0);
                    chk("rst_busy", ia.busy, 0);
                    chk("rst_done", ia.done, 0);
                    chk("rst_ready", ia.din_ready, 0);
                    tick();
                    rst = 1'b0; s_valid = 1'b0; req_a = '0; req_b = '0;
                    exp_sdin = '0; exp_dout = '0;
                    for (int r = 0; r < 4; r++) begin
                        chk("post_rst_ready", ia.din_ready, 0);
                        chk("post_rst_imena", ia.im_ena, 0);
                        chk("post_rst_tdeq", ia.t_deq, 0);
                        tick();
                    end
                    return;
                end
                req_a = 8'($urandom) & ~oh_a;
                req_b = 4'($urandom) & ~oh_b;
                if (i == f) begin
                    req_a = req_a | oh_a;
                    req_b = req_b | oh_b;
                end
                tick();
            end
            s_valid = 1'b0; req_a = '0; req_b = '0;
            chk("imena_off_a", ia.im_ena, 0);
            chk("imena_off_b", ib.im_ena, 0);
        end
        idx = 0; cnt = 0; prev_acc = 1'b0; prev_obs = '0;
        while (idx < TOTAL) begin
            chk("tdeq_drain", ia.t_deq, 1);
            chk("sena_drain", ia.s_ena, 0);
            chk("imena_drain", ia.im_ena, 0);
            chk("ready_drain", ia.din_ready, 0);
            chk("dvalid_a", ia.dout_valid, prev_acc);
            chk("dvalid_b", ib.dout_valid, prev_acc);
            chk("dout_a", ia.dout, exp_dout);
            chk("dout_b", ib.dout, exp_dout);
            chk("dlast_early", ia.dout_last, 0);
            if (prev_acc) begin
                cnt++;
                if (cnt > 1) chk("nondecreasing", ia.dout >= prev_obs, 1);
                prev_obs = ia.dout;
            end
            t_empty = toggle_empty ? ~t_empty : ($urandom_range(0, 3) == 0);
            t_dout = t_empty ? W'($urandom) : sorted[idx];
            start = start_in_drain && (idx == 5);
            acc = !t_empty;
            tick();
            if (acc) begin
                idx++;
                exp_dout = sorted[idx-1];
            end
            prev_acc = acc;
        end
        start = 1'b0; t_empty = 1'b1;
        cnt++;
        chk("pulse_count", cnt, TOTAL);
        chk("dvalid_last", ia.dout_valid, 1);
        chk("dout_last_key", ia.dout, sorted[TOTAL-1]);
        chk("dlast_a", ia.dout_last, 1);
        chk("dlast_b", ib.dout_last, 1);
        chk("done_a", ia.done, 1);
        chk("done_b", ib.done, 1);
        chk("busy_end", ia.busy, 0);
        chk("tdeq_end", ia.t_deq, 0);
        tick();
        chk("dvalid_idle", ia.dout_valid, 0);
        chk("dlast_idle", ia.dout_last, 0);
        chk("done_hold", ia.done, 1);
        chk("tdeq_idle", ia.t_deq, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; din_valid = 1'b0; s_valid = 1'b0;
        t_empty = 1'b1; din = '0; t_dout = '0; req_a = '0; req_b = '0;
        exp_sdin = '0; exp_dout = '0;
        tick(); tick();
        chk("reset_sdin", ia.s_din, 0);
        chk("reset_sena", ia.s_ena, 0);
        chk("reset_imena_a", ia.im_ena, 0);
        chk("reset_imena_b", ib.im_ena, 0);
        chk("reset_tdeq", ia.t_deq, 0);
        chk("reset_dout", ia.dout, 0);
        chk("reset_dvalid", ia.dout_valid, 0);
        chk("reset_dlast", ia.dout_last, 0);
        chk("reset_busy", ia.busy, 0);
        chk("reset_done", ia.done, 0);
        rst = 1'b0;
        din_valid = 1'b1;
        tick();
        #1;
        chk("idle_ready", ia.din_ready, 0);
        chk("idle_busy", ia.busy, 0);
        tick();
        // Baseline: din always valid, 12-cycle network, random root emptiness.
        run(0, 1'b0, 12, -1, 1'b0);
        // Withheld chunk, alternating t_empty, start ignored in drain,
        // new run launched from DONE.
        run(20, 1'b1, 3, -1, 1'b1);
        // Reset during the feed of chunk 3, then a clean restart from IDLE.
        run(0, 1'b0, $urandom_range(2, 6), 3, 1'b0);
        run(0, 1'b1, 2, -1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
